// File: rtl/vec_lane_sequencer_if.sv
// rtl/vec_lane_sequencer_if.sv - bus between the lane sequencer and the shared FP unit
//
// Ports (signals):
//   fu_valid   one-cycle issue strobe            (master -> slave)
//   fu_sel     0 = FP add, 1 = FP mult           (master -> slave)
//   fu_a       operand A, held issue..capture    (master -> slave)
//   fu_b       operand B, held issue..capture    (master -> slave)
//   fu_result  FP result, valid FU_LAT after issue (slave -> master)
interface vec_lane_sequencer_if #(
    parameter int W = 16
);
    logic         fu_valid;
    logic         fu_sel;
    logic [W-1:0] fu_a;
    logic [W-1:0] fu_b;
    logic [W-1:0] fu_result;

    modport master (
        output fu_valid,
        output fu_sel,
        output fu_a,
        output fu_b,
        input  fu_result
    );

    modport slave (
        input  fu_valid,
        input  fu_sel,
        input  fu_a,
        input  fu_b,
        output fu_result
    );
endinterface

// File: rtl/vec_lane_sequencer.sv
// rtl/vec_lane_sequencer.sv - VADD/VDOT/SMUL over 16 half lanes through one shared FP unit
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        request, accepted only when idle
//   opcode       0 VADD, 1 VDOT, 2 SMUL; anything else completes with err
//   op_1, op_2   operand vectors, lane i = bits [16i+15:16i]; SMUL scalar = op_1[15:0]
//   busy         high while lanes are being issued/awaited
//   done         one-cycle completion pulse
//   err          illegal opcode flag, held until the next accept
//   result       per-lane results, or {240'd0, sum} for VDOT
//   fu           master side of the shared FP unit bus
module vec_lane_sequencer #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16,
    parameter int FU_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [3:0]              opcode,
    input  logic [LANES*LANE_W-1:0] op_1,
    input  logic [LANES*LANE_W-1:0] op_2,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [LANES*LANE_W-1:0] result,
    vec_lane_sequencer_if.master    fu
);

    localparam int LCW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WCW = (FU_LAT > 1) ? $clog2(FU_LAT) : 1;

    localparam logic [3:0] OP_VADD = 4'd0;
    localparam logic [3:0] OP_VDOT = 4'd1;
    localparam logic [3:0] OP_SMUL = 4'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t state, state_nx;

    logic [3:0]        op_r;
    logic [LANE_W-1:0] op1_lane [LANES];
    logic [LANE_W-1:0] op2_lane [LANES];
    logic [LANE_W-1:0] a_lane   [LANES];
    logic [LANE_W-1:0] b_lane   [LANES];
    logic [LANE_W-1:0] res_lane [LANES];
    logic [LCW-1:0]    lane;
    logic              phase;      // VDOT: 0 = product, 1 = accumulate
    logic [LANE_W-1:0] acc;
    logic [LANE_W-1:0] prod;
    logic [WCW-1:0]    wait_cnt;
    logic              err_r;

    logic legal, is_vdot, is_smul, wait_last, last_lane;

    // Lane views of the flat operand/result buses
    for (genvar g = 0; g < LANES; g++) begin : g_lanes
        assign op1_lane[g]                   = op_1[g*LANE_W +: LANE_W];
        assign op2_lane[g]                   = op_2[g*LANE_W +: LANE_W];
        assign result[g*LANE_W +: LANE_W]    = res_lane[g];
    end

    assign legal     = (opcode == OP_VADD) || (opcode == OP_VDOT) || (opcode == OP_SMUL);
    assign is_vdot   = (op_r == OP_VDOT);
    assign is_smul   = (op_r == OP_SMUL);
    assign wait_last = (wait_cnt == WCW'(FU_LAT - 1));
    // Last lane found by compare so the counter never relies on wrapping
    assign last_lane = (lane == LCW'(LANES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = legal ? S_ISSUE : S_FAIL;
                end
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                if (wait_last) begin
                    // A VDOT product phase re-issues the same lane for its add
                    if (is_vdot && !phase) begin
                        state_nx = S_ISSUE;
                    end else if (last_lane) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_ISSUE;
                    end
                end
            end
            S_DONE:  state_nx = S_IDLE;
            S_FAIL:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= '0;
            a_lane   <= '{default: '0};
            b_lane   <= '{default: '0};
            res_lane <= '{default: '0};
            lane     <= '0;
            phase    <= 1'b0;
            acc      <= '0;
            prod     <= '0;
            wait_cnt <= '0;
            err_r    <= 1'b0;
        end else begin
            wait_cnt <= (state == S_WAIT && !wait_last) ? wait_cnt + 1'b1 : '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r     <= opcode;
                        a_lane   <= op1_lane;
                        b_lane   <= op2_lane;
                        res_lane <= '{default: '0};
                        lane     <= '0;
                        phase    <= 1'b0;
                        acc      <= '0;
                        prod     <= '0;
                        err_r    <= !legal;
                    end
                end
                S_WAIT: begin
                    if (wait_last) begin
                        if (is_vdot) begin
                            if (!phase) begin
                                prod  <= fu.fu_result;
                                phase <= 1'b1;
                            end else begin
                                acc   <= fu.fu_result;
                                phase <= 1'b0;
                                if (last_lane) begin
                                    res_lane[0] <= fu.fu_result;
                                end else begin
                                    lane <= lane + 1'b1;
                                end
                            end
                        end else begin
                            res_lane[lane] <= fu.fu_result;
                            if (!last_lane) begin
                                lane <= lane + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == S_ISSUE) || (state == S_WAIT);
    assign done = (state == S_DONE) || (state == S_FAIL);
    assign err  = err_r;

    // Operands derive only from latched state, so they hold from issue to capture
    assign fu.fu_valid = (state == S_ISSUE);
    assign fu.fu_sel   = is_smul || (is_vdot && !phase);
    assign fu.fu_a     = (is_vdot && phase) ? acc :
                         is_smul            ? a_lane[0] : a_lane[lane];
    assign fu.fu_b     = (is_vdot && phase) ? prod : b_lane[lane];

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// tb/tb_vec_lane_sequencer.sv - directed self-checking bench for vec_lane_sequencer
module tb_vec_lane_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start1, start3;
    logic [3:0]   opcode;
    logic [255:0] op_1, op_2;
    logic         busy1, done1, err1, busy3, done3, err3;
    logic [255:0] result1, result3;

    always #5 clk = ~clk;

    vec_lane_sequencer_if #(.W(16)) fu1 ();
    vec_lane_sequencer_if #(.W(16)) fu3 ();

    vec_lane_sequencer #(.LANES(16), .LANE_W(16), .FU_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .opcode(opcode),
        .op_1(op_1), .op_2(op_2), .busy(busy1), .done(done1), .err(err1),
        .result(result1), .fu(fu1)
    );

    vec_lane_sequencer #(.LANES(16), .LANE_W(16), .FU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .opcode(opcode),
        .op_1(op_1), .op_2(op_2), .busy(busy3), .done(done3), .err(err3),
        .result(result3), .fu(fu3)
    );

    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e;
        if (h[14:0] == 15'd0) return 0.0;
        m = 1.0 + real'(int'(h[9:0])) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        real        m;
        int         e;
        logic       s;
        logic [9:0] man;
        logic [4:0] ex;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 15;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        man = 10'(int'((m - 1.0) * 1024.0));
        ex  = 5'(e);
        return {s, ex, man};
    endfunction

    function automatic logic [15:0] i2h(input int n);
        return r2h(real'(n));
    endfunction

    function automatic logic [15:0] fp_op(input logic sel, input logic [15:0] a, input logic [15:0] b);
        return sel ? r2h(h2r(a) * h2r(b)) : r2h(h2r(a) + h2r(b));
    endfunction

    // Behavioural FP units: FU_LAT-deep result pipelines, junk when nothing was issued
    logic [15:0] p1;
    logic [15:0] p3 [3];
    always @(posedge clk) begin
        p1    <= fu1.fu_valid ? fp_op(fu1.fu_sel, fu1.fu_a, fu1.fu_b) : 16'hDEAD;
        p3[0] <= fu3.fu_valid ? fp_op(fu3.fu_sel, fu3.fu_a, fu3.fu_b) : 16'hDEAD;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign fu1.fu_result = p1;
    assign fu3.fu_result = p3[2];

    // Issue monitors
    int n1 = 0, s1 = 0, a4k1 = 0, n3 = 0, alt_bad3 = 0;
    always @(posedge clk) begin
        if (fu1.fu_valid) begin
            n1 <= n1 + 1;
            if (fu1.fu_sel) s1 <= s1 + 1;
            if (fu1.fu_a == 16'h4000) a4k1 <= a4k1 + 1;
        end
        if (fu3.fu_valid) begin
            n3 <= n3 + 1;
            if (fu3.fu_sel !== (n3[0] == 1'b0)) alt_bad3 <= alt_bad3 + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int d, input logic [3:0] opc, input logic [255:0] a,
                       input logic [255:0] b, input int poke, output int cyc,
                       output logic [255:0] res, output logic e);
        @(negedge clk);
        opcode = opc;
        op_1   = a;
        op_2   = b;
        if (d == 1) start1 = 1'b1; else start3 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        op_1   = {16{16'h7BFF}};
        op_2   = {16{16'h5A5A}};
        opcode = 4'd1;
        cyc    = 1;
        while (((d == 1) ? done1 : done3) !== 1'b1 && cyc < 400) begin
            if (cyc == poke) begin
                if (d == 1) start1 = 1'b1; else start3 = 1'b1;
                opcode = 4'd2;
            end
            @(negedge clk);
            start1 = 1'b0;
            start3 = 1'b0;
            cyc++;
        end
        res = (d == 1) ? result1 : result3;
        e   = (d == 1) ? err1 : err3;
    endtask

    localparam logic [255:0] ONES = {16{16'h3C00}};
    localparam logic [255:0] TWOS = {16{16'h4000}};

    int           cyc, c0, c1;
    logic [255:0] res, va, vb, vexp;
    logic         e;

    initial begin
        rst_n  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        opcode = 4'd0;
        op_1   = '0;
        op_2   = '0;
        repeat (2) @(negedge clk);
        chk("rst_ctl1", {busy1, done1, err1, fu1.fu_valid, fu1.fu_sel}, '0);
        chk("rst_fu1",  {fu1.fu_a, fu1.fu_b}, '0);
        chk("rst_res1", result1, '0);
        chk("rst_ctl3", {busy3, done3, err3, fu3.fu_valid, fu3.fu_sel, fu3.fu_a, fu3.fu_b}, '0);
        chk("rst_res3", result3, '0);
        rst_n = 1'b1;

        // 1: VADD 1.0 + 1.0 on every lane, FU_LAT=1
        c0 = n1; c1 = s1;
        run(1, 4'd0, ONES, ONES, -1, cyc, res, e);
        chk("t1_cyc", cyc, 33);
        chk("t1_res", res, TWOS);
        chk("t1_err", e, 0);
        chk("t1_busy", busy1, 0);
        chk("t1_strobes", n1 - c0, 16);
        chk("t1_sel", s1 - c1, 0);

        // 1b: VADD lane i = i + (i+1)
        va = '0; vb = '0; vexp = '0;
        for (int i = 0; i < 16; i++) begin
            va   = {i2h(i), va[255:16]};
            vb   = {i2h(i + 1), vb[255:16]};
            vexp = {i2h(2 * i + 1), vexp[255:16]};
        end
        run(1, 4'd0, va, vb, -1, cyc, res, e);
        chk("t1b_res", res, vexp);

        // 2: SMUL by op_1[15:0]=2.0, other op_1 lanes must be ignored
        va = '0;
        for (int i = 0; i < 16; i++) va = {((i == 0) ? 16'h4000 : i2h(i + 5)), va[255:16]};
        c0 = a4k1; c1 = s1;
        run(1, 4'd2, va, ONES, -1, cyc, res, e);
        chk("t2_cyc", cyc, 33);
        chk("t2_res", res, TWOS);
        chk("t2_fu_a", a4k1 - c0, 16);
        chk("t2_sel", s1 - c1, 16);

        // 2b: SMUL 2.0 x lane i = i
        va = ONES;
        va[15:0] = 16'h4000;
        vb = '0; vexp = '0;
        for (int i = 0; i < 16; i++) begin
            vb   = {i2h(i), vb[255:16]};
            vexp = {i2h(2 * i), vexp[255:16]};
        end
        run(1, 4'd2, va, vb, -1, cyc, res, e);
        chk("t2b_res", res, vexp);

        // 4: illegal opcode
        c0 = n1;
        run(1, 4'b0110, ONES, ONES, -1, cyc, res, e);
        chk("t4_cyc", cyc, 1);
        chk("t4_err", e, 1);
        chk("t4_res", res, '0);
        chk("t4_strobes", n1 - c0, 0);

        // 5: start with another opcode while busy is ignored
        run(1, 4'd0, ONES, ONES, 5, cyc, res, e);
        chk("t5_cyc", cyc, 33);
        chk("t5_res", res, TWOS);
        chk("t5_err_clr", e, 0);
        @(negedge clk);
        chk("t5_not_queued", {busy1, done1}, '0);

        // 3: VDOT 1.0 x 1.0 over 16 lanes, FU_LAT=3
        c0 = n3; c1 = alt_bad3;
        run(3, 4'd1, ONES, ONES, -1, cyc, res, e);
        chk("t3_cyc", cyc, 129);
        chk("t3_res", res, {240'd0, 16'h4C00});
        chk("t3_strobes", n3 - c0, 32);
        chk("t3_sel_alt", alt_bad3 - c1, 0);
        chk("t3_err", e, 0);

        // 3b: VDOT sum of lane indices = 120
        va = '0;
        for (int i = 0; i < 16; i++) va = {i2h(i), va[255:16]};
        run(3, 4'd1, va, ONES, -1, cyc, res, e);
        chk("t3b_res", res, {240'd0, i2h(120)});

        // 6: reset during VDOT lane 7, then a fresh VADD
        @(negedge clk);
        opcode = 4'd1;
        op_1   = ONES;
        op_2   = ONES;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        repeat (59) @(negedge clk);
        chk("t6_busy_pre", busy3, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctl", {busy3, done3, err3, fu3.fu_valid}, '0);
        chk("t6_rst_res", result3, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run(3, 4'd0, ONES, ONES, -1, cyc, res, e);
        chk("t6_cyc", cyc, 65);
        chk("t6_res", res, TWOS);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
